// File: rtl/lc4_divider_arbiter.sv
// lc4_divider_arbiter
// Round-robin shares one iterative unsigned 16-bit restoring divider between
// requesters A and B. ITERS_PER_CYCLE restoring steps are done per RUN cycle,
// so an operation spends 16/ITERS_PER_CYCLE cycles in RUN.
// Optional feature macro: LC4_DIV_ZERO_SHORTCUT_EN
//   defined   : divisor 0 jumps from IDLE straight to DONE on the handshake edge
//   undefined : divisor 0 runs the full RUN sequence, result forced to 0/0
//
// Handshakes: a transfer happens at a rising edge where valid & ready are both
// high. req_x_ready is combinational from the valids and only asserts in IDLE;
// requesters must hold valid and operands stable until their handshake and must
// not derive valid from ready. resp_* hold steady in DONE until resp_ready.
module lc4_divider_arbiter #(
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a_valid,
  output logic        req_a_ready,
  input  logic [15:0] req_a_dividend,
  input  logic [15:0] req_a_divisor,
  input  logic        req_b_valid,
  output logic        req_b_ready,
  input  logic [15:0] req_b_dividend,
  input  logic [15:0] req_b_divisor,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_quotient,
  output logic [15:0] resp_remainder,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int N_RUN = 16 / ITERS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(N_RUN - 1);

  generate
    if (!(ITERS_PER_CYCLE == 1 || ITERS_PER_CYCLE == 2 || ITERS_PER_CYCLE == 4 ||
          ITERS_PER_CYCLE == 8 || ITERS_PER_CYCLE == 16)) begin : g_bad_iters
      $error("lc4_divider_arbiter: ITERS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic        rr;        // 0: A favoured on contention, 1: B favoured
  logic [15:0] dvd;       // dividend, shifted left one bit per iteration
  logic [15:0] dsr;       // latched divisor
  logic [15:0] rem;
  logic [15:0] quo;
  logic [4:0]  cnt;
  logic        id;
  logic [15:0] res_q;
  logic [15:0] res_r;

  logic        grant_a;
  logic        grant_b;
  logic        hs_a;
  logic        hs_b;
  logic [15:0] sel_dividend;
  logic [15:0] sel_divisor;

  logic [15:0] rem_n;
  logic [15:0] quo_n;
  logic [15:0] dvd_n;
  logic [15:0] shifted;

  // Arbitration: rr breaks ties, a lone valid always wins.
  always_comb begin
    grant_a      = req_a_valid & (~rr | ~req_b_valid);
    grant_b      = req_b_valid & (rr | ~req_a_valid);
    req_a_ready  = (state == S_IDLE) & grant_a;
    req_b_ready  = (state == S_IDLE) & grant_b;
    hs_a         = req_a_valid & req_a_ready;
    hs_b         = req_b_valid & req_b_ready;
    sel_dividend = grant_b ? req_b_dividend : req_a_dividend;
    sel_divisor  = grant_b ? req_b_divisor  : req_a_divisor;
  end

  // ITERS_PER_CYCLE unrolled restoring shift/subtract steps.
  always_comb begin
    rem_n   = rem;
    quo_n   = quo;
    dvd_n   = dvd;
    shifted = '0;
    for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
      shifted = {rem_n[14:0], dvd_n[15]};
      dvd_n   = {dvd_n[14:0], 1'b0};
      if (shifted >= dsr) begin
        rem_n = shifted - dsr;
        quo_n = {quo_n[14:0], 1'b1};
      end else begin
        rem_n = shifted;
        quo_n = {quo_n[14:0], 1'b0};
      end
    end
  end

  // Control FSM, datapath registers and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rr    <= 1'b0;
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      id    <= 1'b0;
      res_q <= '0;
      res_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs_a | hs_b) begin
            dvd <= sel_dividend;
            dsr <= sel_divisor;
            id  <= hs_b;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
            rr  <= hs_a;   // favour whoever lost this round
`ifdef LC4_DIV_ZERO_SHORTCUT_EN
            if (sel_divisor == 16'h0000) begin
              res_q <= '0;
              res_r <= '0;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          dvd <= dvd_n;
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_CNT) begin
            // The raw iteration yields all-ones for divisor 0; force 0/0.
            res_q <= (dsr == 16'h0000) ? 16'h0000 : quo_n;
            res_r <= (dsr == 16'h0000) ? 16'h0000 : rem_n;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid     = (state == S_DONE);
  assign busy           = (state != S_IDLE);
  assign resp_id        = id;
  assign resp_quotient  = res_q;
  assign resp_remainder = res_r;
  assign dbg_state      = state;

endmodule

// File: tb/tb_lc4_divider_arbiter.sv
// Testbench for lc4_divider_arbiter: directed vector table, contention and
// reset sequences, randomized traffic checked by a scoreboard whose expected
// results come from plain division in a reference function.
module tb_lc4_divider_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT (ITERS_PER_CYCLE = 1) ----------------
  logic        req_a_valid, req_a_ready, req_b_valid, req_b_ready;
  logic [15:0] req_a_dividend, req_a_divisor, req_b_dividend, req_b_divisor;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [15:0] resp_quotient, resp_remainder;
  logic [1:0]  dbg_state;

  lc4_divider_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready),
    .req_a_dividend(req_a_dividend), .req_a_divisor(req_a_divisor),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready),
    .req_b_dividend(req_b_dividend), .req_b_divisor(req_b_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT (ITERS_PER_CYCLE = 4) ----------------
  logic        a4_valid, a4_ready, b4_valid, b4_ready;
  logic [15:0] a4_dd, a4_dv, b4_dd, b4_dv;
  logic        r4_valid, r4_ready, r4_id, busy4;
  logic [15:0] r4_q, r4_r;
  logic [1:0]  dbg_state4;

  lc4_divider_arbiter #(.ITERS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_a_valid(a4_valid), .req_a_ready(a4_ready),
    .req_a_dividend(a4_dd), .req_a_divisor(a4_dv),
    .req_b_valid(b4_valid), .req_b_ready(b4_ready),
    .req_b_dividend(b4_dd), .req_b_divisor(b4_dv),
    .resp_valid(r4_valid), .resp_ready(r4_ready), .resp_id(r4_id),
    .resp_quotient(r4_q), .resp_remainder(r4_r),
    .busy(busy4), .dbg_state(dbg_state4)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned division, divide-by-zero gives 0/0.
  function automatic logic [31:0] ref_div(input logic [15:0] dd, input logic [15:0] dv);
    if (dv == 16'h0000) return 32'h0;
    return {dd / dv, dd % dv};
  endfunction

  function automatic int exp_latency(input logic [15:0] dv);
`ifdef LC4_DIV_ZERO_SHORTCUT_EN
    return (dv == 16'h0000) ? 0 : 16;
`else
    return (dv == 16'h0000) ? 16 : 16;
`endif
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [32:0] exp_q[$];   // {id, quotient, remainder}
  bit          fav_b;      // requester that wins the next tie
  int          hs_a_cnt = 0, hs_b_cnt = 0;
  logic [32:0] held;
  bit          held_v;
  logic [32:0] cur;
  logic        mon_hs_a, mon_hs_b;

  // Samples just before each rising edge; inputs change only on falling edges.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      exp_q.delete();
      fav_b  = 1'b0;
      held_v = 1'b0;
    end else begin
      check("ready_both", 64'(req_a_ready & req_b_ready), 64'd0);
      mon_hs_a = req_a_valid & req_a_ready;
      mon_hs_b = req_b_valid & req_b_ready;
      if (mon_hs_a | mon_hs_b) begin
        if (req_a_valid & req_b_valid) check("arb_tie_winner", 64'(mon_hs_b), 64'(fav_b));
        else check("arb_single_winner", 64'(mon_hs_b), 64'(req_b_valid));
        fav_b = ~mon_hs_b;
        if (mon_hs_b) begin
          exp_q.push_back({1'b1, ref_div(req_b_dividend, req_b_divisor)});
          hs_b_cnt++;
        end else begin
          exp_q.push_back({1'b0, ref_div(req_a_dividend, req_a_divisor)});
          hs_a_cnt++;
        end
      end
      if (resp_valid) begin
        cur = {resp_id, resp_quotient, resp_remainder};
        if (held_v) check("resp_stable", 64'(cur), 64'(held));
        if (resp_ready) begin
          if (exp_q.size() == 0) check("resp_unexpected", 64'(exp_q.size()), 64'd1);
          else check("resp_data", 64'(cur), 64'(exp_q.pop_front()));
          held_v = 1'b0;
        end else begin
          held   = cur;
          held_v = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_hs(input bit b);
    int start, k;
    start = b ? hs_b_cnt : hs_a_cnt;
    k = 0;
    while ((b ? hs_b_cnt : hs_a_cnt) == start && k < 80) begin
      @(negedge clk);
      k++;
    end
    check(b ? "hs_b_timeout" : "hs_a_timeout", 64'(k < 80), 64'd1);
    if (b) req_b_valid = 1'b0;
    else   req_a_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 64'(k < 100), 64'd1);
  endtask

  // One isolated request with latency, busy-length and optional backpressure.
  task automatic single_op(input bit use_b, input logic [15:0] dd, input logic [15:0] dv,
                           input logic [15:0] eq, input logic [15:0] er, input int hold);
    int lat, busy_n, el;
    el = exp_latency(dv);
    @(negedge clk);
    if (use_b) begin
      req_b_valid = 1'b1; req_b_dividend = dd; req_b_divisor = dv;
    end else begin
      req_a_valid = 1'b1; req_a_dividend = dd; req_a_divisor = dv;
    end
    resp_ready = (hold == 0);
    #1;
    check("op_req_ready", 64'(use_b ? req_b_ready : req_a_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    // Operands change after the handshake; the result must not care.
    req_a_dividend = 16'($urandom); req_a_divisor = 16'($urandom);
    req_b_dividend = 16'($urandom); req_b_divisor = 16'($urandom);
    lat = 0;
    busy_n = 0;
    while (!resp_valid && lat < 40) begin
      busy_n += int'(busy);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    busy_n += int'(busy);
    check("op_latency", 64'(lat), 64'(el));
    check("op_quotient", 64'(resp_quotient), 64'(eq));
    check("op_remainder", 64'(resp_remainder), 64'(er));
    check("op_id", 64'(resp_id), 64'(use_b));
    if (hold > 0) begin
      req_a_valid = 1'b1; req_a_dividend = 16'd77; req_a_divisor = 16'd7;
      for (int i = 0; i < hold; i++) begin
        #1;
        check("bp_a_ready_low", 64'(req_a_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_resp_valid", 64'(resp_valid), 64'd1);
        check("bp_quotient", 64'(resp_quotient), 64'(eq));
        busy_n += int'(busy);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_a_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    check("op_resp_done", 64'(resp_valid), 64'd0);
    check("op_idle", 64'(busy), 64'd0);
    check("op_busy_cycles", 64'(busy_n), 64'(el + 1 + hold));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          use_b;
    logic [15:0] dd;
    logic [15:0] dv;
    logic [15:0] eq;
    logic [15:0] er;
    int          hold;
  } vec_t;
  vec_t vecs[9];

  // ---------------- main sequence ----------------
  initial begin
    int k, seen_a, seen_b, resp4_lat;

    vecs[0] = '{1'b0, 16'd100,    16'd7,      16'd14,     16'd2,      0};
    vecs[1] = '{1'b1, 16'hFFFF,   16'h0010,   16'h0FFF,   16'h000F,   0};
    vecs[2] = '{1'b0, 16'd9,      16'd3,      16'd3,      16'd0,      5};
    vecs[3] = '{1'b0, 16'h1234,   16'h0000,   16'h0000,   16'h0000,   0};
    vecs[4] = '{1'b1, 16'hFFFF,   16'h0001,   16'hFFFF,   16'h0000,   0};
    vecs[5] = '{1'b0, 16'h0001,   16'hFFFF,   16'h0000,   16'h0001,   0};
    vecs[6] = '{1'b1, 16'hFFFF,   16'hFFFF,   16'h0001,   16'h0000,   2};
    vecs[7] = '{1'b0, 16'h8000,   16'h0003,   16'h2AAA,   16'h0002,   0};
    vecs[8] = '{1'b1, 16'h0000,   16'h0005,   16'h0000,   16'h0000,   0};

    rst = 1'b1;
    req_a_valid = 0; req_b_valid = 0; resp_ready = 1;
    req_a_dividend = 0; req_a_divisor = 0; req_b_dividend = 0; req_b_divisor = 0;
    a4_valid = 0; b4_valid = 0; r4_ready = 1;
    a4_dd = 0; a4_dv = 0; b4_dd = 0; b4_dv = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_quotient", 64'(resp_quotient), 64'd0);
    check("rst_remainder", 64'(resp_remainder), 64'd0);

    // Contention from reset: A first, then B; then A alone flips rr so the next tie goes to B.
    req_a_valid = 1; req_a_dividend = 16'd200;  req_a_divisor = 16'd9;
    req_b_valid = 1; req_b_dividend = 16'd1000; req_b_divisor = 16'd33;
    #1;
    check("cont_a_ready", 64'(req_a_ready), 64'd1);
    check("cont_b_ready", 64'(req_b_ready), 64'd0);
    wait_hs(1'b0);
    wait_hs(1'b1);
    wait_idle();
    @(negedge clk);
    req_a_valid = 1; req_a_dividend = 16'd500; req_a_divisor = 16'd25;
    wait_hs(1'b0);
    req_a_valid = 1; req_a_dividend = 16'd7;     req_a_divisor = 16'd2;
    req_b_valid = 1; req_b_dividend = 16'hFFFF;  req_b_divisor = 16'd256;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("rr_flip_b_ready", 64'(req_b_ready), 64'd1);
    check("rr_flip_a_ready", 64'(req_a_ready), 64'd0);
    wait_hs(1'b1);
    wait_hs(1'b0);
    wait_idle();

    // Directed vector table.
    for (int i = 0; i < 9; i++)
      single_op(vecs[i].use_b, vecs[i].dd, vecs[i].dv, vecs[i].eq, vecs[i].er, vecs[i].hold);

    // Reset during RUN cycle 8 discards the operation.
    @(negedge clk);
    req_a_valid = 1; req_a_dividend = 16'd300; req_a_divisor = 16'd7;
    @(posedge clk);
    @(negedge clk);
    req_a_valid = 0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_resp_id", 64'(resp_id), 64'd0);
    check("mid_rst_quotient", 64'(resp_quotient), 64'd0);
    check("mid_rst_remainder", 64'(resp_remainder), 64'd0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k += int'(resp_valid);
    end
    check("mid_rst_no_resp", 64'(k), 64'd0);
    single_op(1'b0, 16'd50, 16'd5, 16'd10, 16'd0, 0);

    // Four iterations per cycle instance.
    @(negedge clk);
    b4_valid = 1; b4_dd = 16'hFFFF; b4_dv = 16'h0010;
    #1;
    check("i4_b_ready", 64'(b4_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    b4_valid = 0; b4_dd = 16'h1111; b4_dv = 16'h0003;
    resp4_lat = 0;
    while (!r4_valid && resp4_lat < 40) begin
      @(posedge clk);
      resp4_lat++;
      @(negedge clk);
    end
    check("i4_latency", 64'(resp4_lat), 64'd4);
    check("i4_quotient", 64'(r4_q), 64'h0FFF);
    check("i4_remainder", 64'(r4_r), 64'h000F);
    check("i4_id", 64'(r4_id), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("i4_done", 64'(r4_valid), 64'd0);

    // Randomized traffic with random backpressure.
    seen_a = hs_a_cnt;
    seen_b = hs_b_cnt;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (hs_a_cnt != seen_a) begin seen_a = hs_a_cnt; req_a_valid = 0; end
      if (hs_b_cnt != seen_b) begin seen_b = hs_b_cnt; req_b_valid = 0; end
      if (!req_a_valid && $urandom_range(0, 2) == 0) begin
        req_a_valid = 1;
        req_a_dividend = 16'($urandom);
        req_a_divisor = ($urandom_range(0, 7) == 0) ? 16'h0000 :
                        ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom);
      end
      if (!req_b_valid && $urandom_range(0, 2) == 0) begin
        req_b_valid = 1;
        req_b_dividend = 16'($urandom);
        req_b_divisor = ($urandom_range(0, 7) == 0) ? 16'h0000 :
                        ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    resp_ready = 1;
    k = 0;
    while ((req_a_valid || req_b_valid || busy || exp_q.size() != 0) && k < 300) begin
      @(negedge clk);
      if (hs_a_cnt != seen_a) begin seen_a = hs_a_cnt; req_a_valid = 0; end
      if (hs_b_cnt != seen_b) begin seen_b = hs_b_cnt; req_b_valid = 0; end
      k++;
    end
    check("drain_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("drain_timeout", 64'(k < 300), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog against a hung handshake.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
